simple_gemac_gmii_rx: RTL

//  GMII receive side of the simple GEMAC. Runs on GMII_RX_CLK.
//  - Strips the preamble and SFD.
//  - Removes the 4 FCS bytes from the data stream.
//  - Checks the CRC-32 and the frame length.
//  - Marks frame end with a one-cycle good/bad pulse.
//  - Optionally decodes received 802.3x PAUSE frames for the tx pause logic.

---
 rtl/simple_gemac_gmii_rx_pkg.sv | 45 ++++
 rtl/simple_gemac_gmii_rx_if.sv | 33 +++
 rtl/simple_gemac_gmii_rx_crc.sv | 40 ++++
 rtl/simple_gemac_gmii_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_gemac_gmii_rx_pkg.sv
// Constants and types shared by the simple GEMAC receive and transmit paths.
// Holds the rx state encoding, preamble/SFD bytes, CRC-32 constants and MAC-control constants.
package simple_gemac_gmii_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    PREAMBLE  = 3'd2,
    FRAME     = 3'd3,
    DROP      = 3'd4
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // CRC register is kept MSB-first; data bits enter LSB-first as on the wire.
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

  localparam logic [47:0] FLOW_CTRL_DA  = 48'h0180_C200_0001;
  localparam logic [15:0] MAC_CTRL_TYPE = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE  = 16'h0001;

  // Returns {must_match, byte} for a PAUSE frame header offset; SA and quanta are don't-care.
  function automatic logic [8:0] pause_ref_byte(input logic [15:0] offset);
    logic [8:0] ref_byte;
    ref_byte = 9'h000;
    case (offset)
      16'd0:   ref_byte = {1'b1, FLOW_CTRL_DA[47:40]};
      16'd1:   ref_byte = {1'b1, FLOW_CTRL_DA[39:32]};
      16'd2:   ref_byte = {1'b1, FLOW_CTRL_DA[31:24]};
      16'd3:   ref_byte = {1'b1, FLOW_CTRL_DA[23:16]};
      16'd4:   ref_byte = {1'b1, FLOW_CTRL_DA[15:8]};
      16'd5:   ref_byte = {1'b1, FLOW_CTRL_DA[7:0]};
      16'd12:  ref_byte = {1'b1, MAC_CTRL_TYPE[15:8]};
      16'd13:  ref_byte = {1'b1, MAC_CTRL_TYPE[7:0]};
      16'd14:  ref_byte = {1'b1, PAUSE_OPCODE[15:8]};
      16'd15:  ref_byte = {1'b1, PAUSE_OPCODE[7:0]};
      default: ref_byte = 9'h000;
    endcase
    return ref_byte;
  endfunction

endpackage

// File: rtl/simple_gemac_gmii_rx_if.sv
// Receive-side frame bus from the GMII rx path to its consumer.
interface simple_gemac_gmii_rx_if;
  import simple_gemac_gmii_rx_pkg::*;

  // rx_valid qualifies rx_data for exactly one cycle and there is no ready:
  // the consumer must take every valid byte. rx_ack / rx_error are one-cycle
  // end-of-frame pulses, never high together and never together with rx_valid.
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_error;
  logic        rx_ack;
  logic        pause_rcvd;
  logic [15:0] pause_time_rcvd;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_error,
    output rx_ack,
    output pause_rcvd,
    output pause_time_rcvd
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_error,
    input rx_ack,
    input pause_rcvd,
    input pause_time_rcvd
  );

endinterface

// File: rtl/simple_gemac_gmii_rx_crc.sv
// Byte-wide Ethernet CRC-32 generator/checker, shared by the GEMAC rx and tx paths.
module simple_gemac_gmii_rx_crc
  import simple_gemac_gmii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        calc,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_next;

  // Eight serial LFSR steps unrolled; bit 0 of the byte is the first on the wire.
  always_comb begin
    crc_next = crc_q;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[31] ^ data[i]) begin
        crc_next = {crc_next[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_next = {crc_next[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= CRC_INIT;
    end else if (clear) begin
      crc_q <= CRC_INIT;
    end else if (calc) begin
      crc_q <= crc_next;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/simple_gemac_gmii_rx.sv
// GMII receive path of the simple GEMAC: strips preamble/SFD and FCS, checks CRC-32 and length.
// PAUSE frame decode is built only when SIMPLE_GEMAC_RX_PAUSE_DETECT_EN is defined.
module simple_gemac_gmii_rx
  import simple_gemac_gmii_rx_pkg::*;
#(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 8192
) (
  input  logic                   GMII_RX_CLK,
  input  logic                   reset_n,
  input  logic                   GMII_RX_DV,
  input  logic                   GMII_RX_ER,
  input  logic [7:0]             GMII_RXD,
  output logic                   rx_clk,
  simple_gemac_gmii_rx_if.master rx,
  output rx_state_e              dbg_state
);

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

  logic        dv_d;
  logic        er_d;
  logic [7:0]  rxd_d;
  logic        primed_q;

  rx_state_e   state_q;
  rx_state_e   state_next;

  logic [7:0]  dly_q [4];
  logic [2:0]  fill_q;
  logic [15:0] len_q;
  logic        er_seen_q;
  logic        drop_report_q;

  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        rx_ack_q;
  logic        rx_error_q;

  logic        frame_byte;
  logic        end_good;
  logic        end_bad;
  logic        drop_from_frame;
  logic        frame_ok;
  logic        crc_clear;
  logic        crc_calc;
  logic [31:0] crc_out;

  assign rx_clk    = GMII_RX_CLK;
  assign dbg_state = state_q;

  // primed_q keeps WAIT_IDLE from trusting the reset value of dv_d.
  always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      dv_d     <= 1'b0;
      er_d     <= 1'b0;
      rxd_d    <= 8'h00;
      primed_q <= 1'b0;
    end else begin
      dv_d     <= GMII_RX_DV;
      er_d     <= GMII_RX_ER;
      rxd_d    <= GMII_RXD;
      primed_q <= 1'b1;
    end
  end

  assign frame_ok = (crc_out == CRC_RESIDUE) && (len_q >= MIN_LEN) &&
                    (len_q <= MAX_LEN) && !er_seen_q;

  always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next      = state_q;
    frame_byte      = 1'b0;
    end_good        = 1'b0;
    end_bad         = 1'b0;
    drop_from_frame = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (primed_q && !dv_d) state_next = IDLE;
      end
      IDLE: begin
        if (dv_d) begin
          if (rxd_d == PREAMBLE_BYTE)  state_next = PREAMBLE;
          else if (rxd_d == SFD_BYTE)  state_next = FRAME;
          else                         state_next = DROP;
        end
      end
      PREAMBLE: begin
        if (!dv_d)                        state_next = IDLE;
        else if (rxd_d == SFD_BYTE)       state_next = FRAME;
        else if (rxd_d != PREAMBLE_BYTE)  state_next = DROP;
      end
      FRAME: begin
        if (!dv_d) begin
          state_next = IDLE;
          end_good   = frame_ok;
          end_bad    = !frame_ok;
        end else if (len_q == MAX_LEN) begin
          state_next      = DROP;
          drop_from_frame = 1'b1;
        end else begin
          frame_byte = 1'b1;
        end
      end
      DROP: begin
        if (!dv_d) begin
          state_next = IDLE;
          end_bad    = drop_report_q;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  assign crc_clear = (state_q != FRAME);
  assign crc_calc  = frame_byte;

  simple_gemac_gmii_rx_crc u_crc (
    .clk     (GMII_RX_CLK),
    .reset_n (reset_n),
    .clear   (crc_clear),
    .calc    (crc_calc),
    .data    (rxd_d),
    .crc_out (crc_out)
  );

  // Four-byte delay line: a byte leaves only when a newer one arrives, so the
  // last four bytes of a frame (the FCS) are never forwarded.
  always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) dly_q[i] <= 8'h00;
      fill_q        <= 3'd0;
      len_q         <= 16'd0;
      er_seen_q     <= 1'b0;
      drop_report_q <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_ack_q      <= 1'b0;
      rx_error_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ack_q   <= end_good;
      rx_error_q <= end_bad;
      if (frame_byte) begin
        dly_q[0] <= rxd_d;
        dly_q[1] <= dly_q[0];
        dly_q[2] <= dly_q[1];
        dly_q[3] <= dly_q[2];
        if (fill_q == 3'd4) begin
          rx_data_q  <= dly_q[3];
          rx_valid_q <= 1'b1;
        end else begin
          fill_q <= fill_q + 3'd1;
        end
        if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
        if (er_d) er_seen_q <= 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) dly_q[i] <= 8'h00;
        fill_q    <= 3'd0;
        len_q     <= 16'd0;
        er_seen_q <= 1'b0;
      end
      if (drop_from_frame) begin
        drop_report_q <= 1'b1;
      end else if (state_next != DROP) begin
        drop_report_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data  = rx_data_q;
  assign rx.rx_valid = rx_valid_q;
  assign rx.rx_ack   = rx_ack_q;
  assign rx.rx_error = rx_error_q;

`ifdef SIMPLE_GEMAC_RX_PAUSE_DETECT_EN
  logic        pause_match_q;
  logic [15:0] pause_quanta_q;
  logic        pause_rcvd_q;
  logic [15:0] pause_time_q;
  logic [8:0]  pause_ref;

  // len_q is the offset of the byte currently in rxd_d.
  assign pause_ref = pause_ref_byte(len_q);

  always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
    if (!reset_n) begin
      pause_match_q  <= 1'b1;
      pause_quanta_q <= 16'h0000;
      pause_rcvd_q   <= 1'b0;
      pause_time_q   <= 16'h0000;
    end else begin
      pause_rcvd_q <= 1'b0;
      if (state_q != FRAME) begin
        pause_match_q <= 1'b1;
      end else if (frame_byte) begin
        if (pause_ref[8] && (rxd_d != pause_ref[7:0])) pause_match_q <= 1'b0;
        if (len_q == 16'd16) pause_quanta_q[15:8] <= rxd_d;
        if (len_q == 16'd17) pause_quanta_q[7:0]  <= rxd_d;
      end
      if (end_good && pause_match_q) begin
        pause_rcvd_q <= 1'b1;
        pause_time_q <= pause_quanta_q;
      end
    end
  end

  assign rx.pause_rcvd      = pause_rcvd_q;
  assign rx.pause_time_rcvd = pause_time_q;
`else
  assign rx.pause_rcvd      = 1'b0;
  assign rx.pause_time_rcvd = 16'h0000;
`endif

endmodule
